// File: rtl/dot_frame_mac.sv
// Frame-level multiply-accumulate: loads vector A, streams vector B through a MAC,
// then hands the 2*WIDTH-bit dot product to the word transmitter.
module dot_frame_mac #(
  parameter int N     = 2,
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  input  logic                 tx_busy,
  output logic [2*WIDTH-1:0]   tx_data,
  output logic                 tx_start,
  output logic                 busy,
  output logic                 overrun
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    SEND   = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [2*WIDTH-1:0]    acc_reg, acc_next;
  logic [2*WIDTH-1:0]    tx_data_reg, tx_data_next;
  logic                  tx_start_reg, tx_start_next;
  logic                  overrun_reg, overrun_next;
  logic                  a_we;

  logic [WIDTH-1:0]      a_mem [N];
  logic [WIDTH-1:0]      a_rd;
  logic [2*WIDTH-1:0]    product;
  logic [2*WIDTH-1:0]    mac_sum;

  // A element is read in the same cycle its B partner arrives, so the read is combinational.
  assign a_rd    = a_mem[idx_reg];
  assign product = (2*WIDTH)'(a_rd) * (2*WIDTH)'(in_data);
  assign mac_sum = acc_reg + product;

  always_ff @(posedge clk) begin
    if (a_we) begin
      a_mem[idx_reg] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= LOAD_A;
      idx_reg      <= '0;
      acc_reg      <= '0;
      tx_data_reg  <= '0;
      tx_start_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      acc_reg      <= acc_next;
      tx_data_reg  <= tx_data_next;
      tx_start_reg <= tx_start_next;
      overrun_reg  <= overrun_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    acc_next      = acc_reg;
    tx_data_next  = tx_data_reg;
    tx_start_next = 1'b0;
    overrun_next  = overrun_reg;
    a_we          = 1'b0;

    case (state_reg)
      LOAD_A: begin
        if (in_valid) begin
          a_we = 1'b1;
          if (idx_reg == IDX_LAST) begin
            idx_next   = '0;
            state_next = LOAD_B;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      LOAD_B: begin
        if (in_valid) begin
          if (idx_reg == IDX_LAST) begin
            tx_data_next = mac_sum;
            acc_next     = '0;
            idx_next     = '0;
            state_next   = SEND;
          end else begin
            acc_next = mac_sum;
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      SEND: begin
        // Bytes arriving while a result waits are lost; flag it and keep the frame boundary.
        if (in_valid) begin
          overrun_next = 1'b1;
        end
        if (!tx_busy) begin
          tx_start_next = 1'b1;
          state_next    = LOAD_A;
        end
      end
      default: begin
        state_next = LOAD_A;
        idx_next   = '0;
      end
    endcase
  end

  assign tx_data  = tx_data_reg;
  assign tx_start = tx_start_reg;
  assign overrun  = overrun_reg;
  assign busy     = (state_reg != LOAD_A) || (idx_reg != '0);

endmodule

// File: tb/tb_dot_frame_mac.sv
// Randomized and directed bench for dot_frame_mac with a frame-level reference model
// and a tx_start-driven scoreboard.
module tb_dot_frame_mac;

  localparam int N     = 2;
  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [WIDTH-1:0]   in_data;
  logic               in_valid;
  logic               tx_busy;
  logic [2*WIDTH-1:0] tx_data;
  logic               tx_start;
  logic               busy;
  logic               overrun;

  dot_frame_mac #(.N(N), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: bytes of the frame in progress and the pending-result flag.
  int               frame_q[$];
  logic [15:0]      exp_q[$];
  bit               in_send     = 1'b0;
  bit               launch_exp  = 1'b0;
  bit               overrun_exp = 1'b0;
  logic [15:0]      data_exp    = 16'h0;
  bit               mon_en      = 1'b0;
  int               launches    = 0;

  function automatic logic [15:0] dot_of(input int f[$]);
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += f[i] * f[N + i];
    return 16'(s);
  endfunction

  always @(posedge clk) begin
    launch_exp = 1'b0;
    if (!rst) begin
      frame_q.delete();
      exp_q.delete();
      in_send     = 1'b0;
      overrun_exp = 1'b0;
      data_exp    = 16'h0;
    end else if (in_send) begin
      if (in_valid) overrun_exp = 1'b1;
      if (!tx_busy) begin
        in_send    = 1'b0;
        launch_exp = 1'b1;
      end
    end else if (in_valid) begin
      frame_q.push_back(int'(in_data));
      if (frame_q.size() == 2 * N) begin
        data_exp = dot_of(frame_q);
        exp_q.push_back(data_exp);
        frame_q.delete();
        in_send = 1'b1;
      end
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: per-cycle output checks plus scoreboard pop on each launch.
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      check("tx_start", tx_start, launch_exp);
      check("tx_data_hold", tx_data, data_exp);
      check("busy", busy, (in_send || frame_q.size() != 0));
      check("overrun", overrun, overrun_exp);
      if (tx_start) begin
        launches++;
        check("no_double_start", prev_start, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_launch", 1, 0);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("scoreboard_tx_data", tx_data, e);
          $display("launch tx_data=%0d expected=%0d", tx_data, e);
        end
      end
      prev_start = tx_start;
    end
  end

  task automatic send_byte(input int b);
    in_valid = 1'b1;
    in_data  = WIDTH'(b);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int b0, input int b1, input int b2, input int b3);
    send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3);
  endtask

  task automatic wait_launch(input string name, input int exp, input int lat);
    int n;
    bit seen;
    seen = 1'b0;
    for (n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (tx_start) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check({name, "_launch_timeout"}, 0, 1);
    end else begin
      check({name, "_result"}, tx_data, exp);
      if (lat > 0) check({name, "_latency"}, n, lat);
    end
  endtask

  initial begin
    int l0;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    check("reset_tx_data", tx_data, 0);
    check("reset_tx_start", tx_start, 0);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);
    rst = 1'b1;
    @(negedge clk);

    // Basic frame: 13*1 + 5*3 = 28, launch two cycles after the last strobe.
    send_frame(13, 5, 1, 3);
    check("basic_busy_send", busy, 1);
    wait_launch("basic", 28, 1);
    check("basic_busy_after_launch", busy, 0);
    repeat (2) @(negedge clk);

    send_frame(255, 255, 255, 255);
    wait_launch("overflow", 16'hFC02, 1);

    // Backpressure with an overrun byte while the result waits.
    tx_busy = 1'b1;
    send_frame(6, 7, 8, 9);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) send_byte(7);
      else @(negedge clk);
      check("bp_no_start", tx_start, 0);
      check("bp_data", tx_data, 111);
    end
    check("overrun_set", overrun, 1);
    tx_busy = 1'b0;
    wait_launch("backpressure", 111, 1);
    send_frame(2, 2, 3, 3);
    wait_launch("after_overrun", 12, 1);
    check("overrun_sticky", overrun, 1);

    // Reset mid-frame discards the partial frame and clears all outputs.
    send_byte(9); send_byte(9); send_byte(4);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mrst_tx_data", tx_data, 0);
    check("mrst_tx_start", tx_start, 0);
    check("mrst_busy", busy, 0);
    check("mrst_overrun", overrun, 0);
    send_frame(1, 2, 3, 4);
    wait_launch("post_reset", 11, 1);

    // Back-to-back: next frame's first byte lands in the launch cycle.
    l0 = launches;
    send_frame(1, 1, 1, 1);
    @(negedge clk);
    check("b2b_first_start", tx_start, 1);
    check("b2b_first_data", tx_data, 2);
    send_frame(0, 10, 7, 7);
    wait_launch("b2b_second", 70, 1);
    check("b2b_launch_count", launches - l0, 2);
    check("b2b_overrun_clear", overrun, 0);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      in_valid = ($urandom_range(0, 99) < 55);
      in_data  = WIDTH'($urandom);
      tx_busy  = ($urandom_range(0, 99) < 35);
      rst      = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end
    in_valid = 1'b0; rst = 1'b1; tx_busy = 1'b0;
    repeat (5) @(negedge clk);
    check("drain_scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
